// File: rtl/cmp_pkg.sv
// Shared definitions for the comparator-sharing arbiter.
// Holds the op-code encodings, the sequencer state encodings and the op-code width.
package cmp_pkg;

    localparam int OPW = 3;

    localparam logic [OPW-1:0] OP_LT   = 3'd0;
    localparam logic [OPW-1:0] OP_GT   = 3'd1;
    localparam logic [OPW-1:0] OP_LE   = 3'd2;
    localparam logic [OPW-1:0] OP_GE   = 3'd3;
    localparam logic [OPW-1:0] OP_EQ   = 3'd4;
    localparam logic [OPW-1:0] OP_NEQ  = 3'd5;
    localparam logic [OPW-1:0] OP_CEQ  = 3'd6;
    localparam logic [OPW-1:0] OP_CNEQ = 3'd7;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

endpackage

// File: rtl/cmp_unit.sv
// Combinational unsigned relational/equality comparator; the single shared resource.
// Ports:
//   a, b : W-bit unsigned operands
//   op   : op code (LT, GT, LE, GE, EQ, NEQ, CEQ, CNEQ)
//   res  : 1-bit comparison result
module cmp_unit
    import cmp_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [OPW-1:0] op,
    output logic           res
);

    always_comb begin
        res = 1'b0;
        case (op)
            OP_LT:   res = (a <  b);
            OP_GT:   res = (a >  b);
            OP_LE:   res = (a <= b);
            OP_GE:   res = (a >= b);
            OP_EQ:   res = (a == b);
            OP_NEQ:  res = (a != b);
            // Case equality always resolves to 0/1, even with X/Z operands.
            OP_CEQ:  res = (a === b);
            OP_CNEQ: res = (a !== b);
            default: res = 1'b0;
        endcase
    end

endmodule

// File: rtl/cmp_share_arb.sv
// Round-robin arbiter and sequencer sharing one comparator among NREQ requesters.
//
// state  | meaning
// IDLE   | no operation in flight; arbitrate among requesters
// EXEC   | comparator evaluates latched operands; result registered at the edge
// RESP   | result presented; on handshake, count it and optionally re-arbitrate
//
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   req_valid/req_ready  : per-requester handshake (req_ready one-hot or zero)
//   req_a, req_b, req_op : packed per-requester operands and op codes
//   rsp_valid/rsp_ready  : result handshake
//   rsp_id, rsp_res, rsp_op : owner id, comparison result, executed op
//   cmp_count            : saturating count of completed responses
module cmp_share_arb
    import cmp_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*3-1:0] req_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_res,
    output logic [OPW-1:0]    rsp_op,
    output logic [CNTW-1:0]   cmp_count
);

    logic [1:0]     state;
    logic [IDW-1:0] ptr;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [OPW-1:0] op_q;
    logic [IDW-1:0] id_q;
    logic           cmp_res;

    logic           arb_en;
    logic           found;
    logic           take;
    logic [IDW-1:0] win;

    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    cmp_unit #(.W(W)) u_cmp (
        .a   (a_q),
        .b   (b_q),
        .op  (op_q),
        .res (cmp_res)
    );

    // Arbitration is open in IDLE and in the RESP cycle where the result handshakes.
    assign arb_en = !rst && ((state == S_IDLE) ||
                             (state == S_RESP && rsp_valid && rsp_ready));

    // Scan from the farthest offset down so the nearest valid requester to ptr wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[rr_idx(ptr, k)]) begin
                found = 1'b1;
                win   = rr_idx(ptr, k);
            end
        end
    end

    assign take      = arb_en && found;
    assign req_ready = take ? (NREQ'(1) << win) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            id_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_res   <= 1'b0;
            rsp_op    <= '0;
            cmp_count <= '0;
        end else begin
            if (take) begin
                a_q  <= req_a[win*W +: W];
                b_q  <= req_b[win*W +: W];
                op_q <= req_op[win*3 +: 3];
                id_q <= win;
                ptr  <= (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
            end

            case (state)
                S_IDLE: begin
                    if (take) state <= S_EXEC;
                end
                S_EXEC: begin
                    rsp_res   <= cmp_res;
                    rsp_id    <= id_q;
                    rsp_op    <= op_q;
                    rsp_valid <= 1'b1;
                    state     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (cmp_count != '1) cmp_count <= cmp_count + CNTW'(1);
                        state <= take ? S_EXEC : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_share_arb.sv
module tb_cmp_share_arb;
    import cmp_pkg::*;

    localparam int NREQ = 4;
    localparam int W    = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 4;
    localparam int CMAX = (1 << CNTW) - 1;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*3-1:0] req_op;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_res;
    logic [2:0]        rsp_op;
    logic [CNTW-1:0]   cmp_count;

    cmp_share_arb #(.NREQ(NREQ), .W(W), .IDW(IDW), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_res   (rsp_res),
        .rsp_op    (rsp_op),
        .cmp_count (cmp_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int id;
        int res;
        int op;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: how many results are in flight and where they are.
    // m_pend: 0 nothing in flight, 1 being computed, 2 presented as a result.
    int m_pend = 0;
    int m_ptr  = 0;
    int m_cnt  = 0;
    int last_grant = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int golden(input int a, input int b, input int op);
        case (op)
            0: return (a <  b) ? 1 : 0;
            1: return (a >  b) ? 1 : 0;
            2: return (a <= b) ? 1 : 0;
            3: return (a >= b) ? 1 : 0;
            4: return (a == b) ? 1 : 0;
            5: return (a != b) ? 1 : 0;
            6: return (a == b) ? 1 : 0;
            default: return (a != b) ? 1 : 0;
        endcase
    endfunction

    task automatic model_step();
        int   g;
        int   idx;
        int   nxt;
        exp_t e;
        logic [31:0] exp_ready;
        g = -1;
        if (!rst && (m_pend == 0 || (m_pend == 2 && rsp_ready))) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (req_valid[idx] && g < 0) g = idx;
            end
        end
        exp_ready = (g >= 0) ? (32'd1 << g) : 32'd0;
        chk("req_ready", 32'(req_ready), exp_ready);
        chk("rsp_valid", 32'(rsp_valid), (m_pend == 2) ? 32'd1 : 32'd0);
        chk("cmp_count", 32'(cmp_count), 32'(m_cnt));
        if (m_pend == 2 && !rsp_ready && sb.size() > 0) begin
            chk("hold_id",  32'(rsp_id),  32'(sb[0].id));
            chk("hold_res", 32'(rsp_res), 32'(sb[0].res));
            chk("hold_op",  32'(rsp_op),  32'(sb[0].op));
        end
        last_grant = g;
        if (rst) begin
            m_pend = 0;
            m_ptr  = 0;
            m_cnt  = 0;
            sb.delete();
        end else begin
            nxt = m_pend;
            if (m_pend == 1) nxt = 2;
            else if (m_pend == 2 && rsp_ready) begin
                if (m_cnt < CMAX) m_cnt++;
                nxt = 0;
            end
            if (g >= 0) begin
                e.id  = g;
                e.op  = int'(req_op[g*3 +: 3]);
                e.res = golden(int'(req_a[g*W +: W]), int'(req_b[g*W +: W]), e.op);
                sb.push_back(e);
                m_ptr = (g + 1) % NREQ;
                nxt   = 1;
            end
            m_pend = nxt;
        end
    endtask

    // Monitor: pops the oldest expected result on every response handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_id",  32'(rsp_id),  32'(e.id));
                chk("rsp_res", 32'(rsp_res), 32'(e.res));
                chk("rsp_op",  32'(rsp_op),  32'(e.op));
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_operands();
        req_a  = NREQ*W'($urandom);
        req_b  = NREQ*W'($urandom);
        req_op = (NREQ*3)'($urandom);
    endtask

    task automatic set_req(input int r, input int a, input int b, input int op);
        req_a[r*W +: W] = W'(a);
        req_b[r*W +: W] = W'(b);
        req_op[r*3 +: 3] = 3'(op);
    endtask

    // Hold the current request pattern until the model sees a grant.
    task automatic wait_grant(input bit rand_ready, output int g);
        int n;
        n = 0;
        g = -1;
        while (g < 0 && n < 40) begin
            if (rand_ready) rsp_ready = ($urandom_range(0, 3) != 0);
            cyc();
            g = last_grant;
            n++;
        end
        if (g < 0) chk("grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) cyc();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int g;
        int r;
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc();
        chk("reset_rsp_id",  32'(rsp_id),    32'd0);
        chk("reset_rsp_res", 32'(rsp_res),   32'd0);
        chk("reset_rsp_op",  32'(rsp_op),    32'd0);
        chk("reset_count",   32'(cmp_count), 32'd0);
        rst = 1'b0;

        // Single request: 10 > 9 on requester 0.
        rsp_ready = 1'b1;
        set_req(0, 10, 9, int'(OP_GT));
        req_valid = 4'b0001;
        cyc();
        chk("single_grant", 32'(last_grant), 32'd0);
        req_valid = '0;
        repeat (4) cyc();
        chk("single_count", 32'(cmp_count), 32'd1);

        // Operator sweep with random requester and random backpressure.
        for (int a = 10; a <= 15; a++) begin
            for (int b = 9; b <= 13; b++) begin
                for (int op = 0; op < 8; op++) begin
                    rand_operands();
                    r = $urandom_range(0, NREQ - 1);
                    set_req(r, a, b, op);
                    req_valid = NREQ'(1) << r;
                    wait_grant(1'b1, g);
                    chk("sweep_grant", 32'(g), 32'(r));
                    req_valid = '0;
                end
            end
        end
        drain();

        // Fairness: all requesters continuously valid from pointer 0.
        do_reset();
        rsp_ready = 1'b1;
        req_valid = '1;
        for (int i = 0; i < 6; i++) begin
            rand_operands();
            wait_grant(1'b0, g);
            chk("fair_order", 32'(g), 32'(i % NREQ));
        end
        drain();
        chk("fair_count", 32'(cmp_count), 32'd6);

        // Backpressure: result held, no grants, then handshake + grant of req2.
        rsp_ready = 1'b0;
        rand_operands();
        req_valid = 4'b0001;
        wait_grant(1'b0, g);
        chk("bp_first_grant", 32'(g), 32'd0);
        req_valid = '0;
        repeat (2) cyc();
        req_valid = 4'b0100;
        repeat (5) cyc();
        chk("bp_count_held", 32'(cmp_count), 32'd6);
        rsp_ready = 1'b1;
        cyc();
        chk("bp_release_grant", 32'(last_grant), 32'd2);
        drain();

        // Reset while EXEC: discards the op, pointer back to 0.
        rand_operands();
        req_valid = 4'b0001;
        wait_grant(1'b0, g);
        req_valid = 4'b1010;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_count",     32'(cmp_count), 32'd0);
        cyc();
        chk("rst_first_grant", 32'(last_grant), 32'd1);
        drain();

        // Saturation: 17 responses with a 4-bit counter.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            rand_operands();
            r = $urandom_range(0, NREQ - 1);
            req_valid = NREQ'(1) << r;
            wait_grant(1'b1, g);
            req_valid = '0;
        end
        drain();
        chk("sat_count", 32'(cmp_count), 32'(CMAX));

        // Random traffic: requesters come and go, operands change every cycle.
        for (int i = 0; i < 300; i++) begin
            rand_operands();
            req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            rsp_ready = $urandom_range(0, 1) != 0;
            cyc();
        end
        drain();
        chk("sat_stays", 32'(cmp_count), 32'(CMAX));
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
